// File: rtl/instr_fetch_unit_i_0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_i_0_pkg
// Description : Shared constants and fetch-state encoding for the core-0
//               instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_i_0_pkg;

    localparam int unsigned c_ADDRESSSIZE = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

endpackage : instr_fetch_unit_i_0_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_i_0_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_i_0_fifo
// Description : Synchronous fetch buffer holding {pc, instr} pairs, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit_i_0_fifo #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem_pc   [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_pop   = pop & ~w_empty & ~flush;
    // A full buffer only accepts a push alongside a pop.
    assign w_push  = push & ~flush & ((r_count != c_depth) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= push_pc;
            r_mem_data[r_wr_ptr] <= push_data;
        end
    end

    assign valid     = ~w_empty;
    assign head_pc   = w_empty ? '0 : r_mem_pc[r_rd_ptr];
    assign head_data = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign count     = r_count;

endmodule : instr_fetch_unit_i_0_fifo
`default_nettype wire

// File: rtl/instr_fetch_unit_i_0.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_i_0
// Description : Core-0 instruction fetch stage: drives the I-cache request,
//               buffers returned words for decode, handles PC redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit_i_0
    import instr_fetch_unit_i_0_pkg::*;
#(
    parameter  int unsigned       ADDR_W     = c_ADDRESSSIZE,
    parameter  int unsigned       FIFO_DEPTH = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter  int unsigned       PC_STEP    = 1,
    localparam int unsigned       CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              PrRd,
    output logic [ADDR_W-1:0] Address,
    input  logic [ADDR_W-1:0] Data_Bus,
    input  logic              CPU_stall,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam logic [CNT_W-1:0]  c_depth    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  c_depth_m1 = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_pc_step  = ADDR_W'(PC_STEP);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_target;
    logic              r_prrd;

    logic              w_complete;
    logic              w_push;
    logic              w_pop;
    logic              w_has_room;
    logic              w_room_after;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_complete   = r_prrd & ~CPU_stall;
    assign w_pop        = instr_valid & instr_ready & ~redirect_valid;
    assign w_push       = w_complete & ~redirect_valid &
                          ((r_state == S_REQ) | (r_state == S_WAIT));
    assign w_has_room   = (fifo_count < c_depth);
    // Occupancy after this push: a simultaneous pop keeps it below full.
    assign w_room_after = w_pop | (fifo_count < c_depth_m1);
    assign w_next_addr  = r_addr + c_pc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_target <= RESET_PC;
            r_prrd   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end else if (fetch_en && w_has_room) begin
                        r_addr  <= r_pc;
                        r_prrd  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (CPU_stall) begin
                        // A miss in flight must run to completion before redirecting.
                        if (redirect_valid) begin
                            r_target <= redirect_pc;
                            r_state  <= S_DRAIN;
                        end else begin
                            r_state  <= S_WAIT;
                        end
                    end else if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_prrd  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_pc <= w_next_addr;
                        if (fetch_en && w_room_after) begin
                            r_addr  <= w_next_addr;
                            r_state <= S_REQ;
                        end else begin
                            r_prrd  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!CPU_stall) begin
                        r_pc    <= redirect_valid ? redirect_pc : r_target;
                        r_prrd  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (redirect_valid) begin
                        r_target <= redirect_pc;
                    end
                end
                default: begin
                    r_prrd  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign PrRd    = r_prrd;
    assign Address = r_addr;

    instr_fetch_unit_i_0_fifo #(
        .DATA_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_pc   (r_addr),
        .push_data (Data_Bus),
        .pop       (w_pop),
        .valid     (instr_valid),
        .head_pc   (instr_pc),
        .head_data (instr_data),
        .count     (fifo_count)
    );

endmodule : instr_fetch_unit_i_0
`default_nettype wire

// File: tb/tb_instr_fetch_unit_i_0.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit_i_0
// Description : Directed self-checking bench for instr_fetch_unit_i_0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit_i_0;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        PrRd;
    logic [31:0] Address;
    logic [31:0] Data_Bus;
    logic        CPU_stall;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    // I-cache stand-in: each address returns a distinct word.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign Data_Bus = word(Address);

    instr_fetch_unit_i_0 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .PrRd           (PrRd),
        .Address        (Address),
        .Data_Bus       (Data_Bus),
        .CPU_stall      (CPU_stall),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        CPU_stall      = 1'b0;
        instr_ready    = 1'b1;
        #2;
        check("rst_prrd",  32'(PrRd), 32'd0);
        check("rst_addr",  Address, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_data",  instr_data, 32'd0);
        check("rst_pc",    instr_pc, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Streaming hits: one word per cycle.
        tick();
        check("t1_prrd", 32'(PrRd), 32'd1);
        check("t1_addr", Address, 32'd0);
        check("t1_valid0", 32'(instr_valid), 32'd0);
        tick();
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_pc0",   instr_pc, 32'd0);
        check("t1_data0", instr_data, word(32'd0));
        check("t1_cnt",   32'(fifo_count), 32'd1);
        check("t1_addr1", Address, 32'd1);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check("t1_pc",   instr_pc, 32'(k));
            check("t1_data", instr_data, word(32'(k)));
            check("t1_addr", Address, 32'(k + 1));
            check("t1_cnt",  32'(fifo_count), 32'd1);
        end

        // Miss at address 3 held for five cycles.
        CPU_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_prrd", 32'(PrRd), 32'd1);
            check("t2_addr", Address, 32'd3);
            check("t2_cnt",  32'(fifo_count), 32'd0);
        end
        CPU_stall = 1'b0;
        tick();
        check("t2_cnt1", 32'(fifo_count), 32'd1);
        check("t2_pc",   instr_pc, 32'd3);
        check("t2_data", instr_data, word(32'd3));
        check("t2_addr", Address, 32'd4);
        tick();
        check("t2_pc4",  instr_pc, 32'd4);
        check("t2_cnt2", 32'(fifo_count), 32'd1);

        // Back-pressure fills the buffer.
        instr_ready = 1'b0;
        tick();
        check("t3_cnt2", 32'(fifo_count), 32'd2);
        tick();
        check("t3_cnt3", 32'(fifo_count), 32'd3);
        tick();
        check("t3_cnt4", 32'(fifo_count), 32'd4);
        check("t3_prrd0", 32'(PrRd), 32'd0);
        check("t3_head",  instr_pc, 32'd4);
        tick();
        check("t3_cnt4b", 32'(fifo_count), 32'd4);
        check("t3_idle",  32'(PrRd), 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t3_pop",   32'(fifo_count), 32'd3);
        check("t3_prrdp", 32'(PrRd), 32'd0);
        check("t3_head5", instr_pc, 32'd5);
        tick();
        check("t3_reissue", 32'(PrRd), 32'd1);
        check("t3_addr8",   Address, 32'd8);
        tick();
        check("t3_full", 32'(fifo_count), 32'd4);
        check("t3_stop", 32'(PrRd), 32'd0);

        // Redirect while a miss is outstanding.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd6;
        tick();
        redirect_valid = 1'b0;
        check("t4_flush0", 32'(fifo_count), 32'd0);
        check("t4_valid0", 32'(instr_valid), 32'd0);
        tick();
        check("t4_addr6", Address, 32'd6);
        tick();
        check("t4_cnt1",  32'(fifo_count), 32'd1);
        check("t4_pc6",   instr_pc, 32'd6);
        check("t4_addr7", Address, 32'd7);
        CPU_stall = 1'b1;
        tick();
        check("t4_wait", Address, 32'd7);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("t4_flush", 32'(fifo_count), 32'd0);
        check("t4_fval",  32'(instr_valid), 32'd0);
        check("t4_prrd",  32'(PrRd), 32'd1);
        check("t4_hold",  Address, 32'd7);
        tick();
        check("t4_prrd2", 32'(PrRd), 32'd1);
        check("t4_hold2", Address, 32'd7);
        CPU_stall = 1'b0;
        tick();
        check("t4_drop",    32'(PrRd), 32'd0);
        check("t4_discard", 32'(fifo_count), 32'd0);
        tick();
        check("t4_newreq", 32'(PrRd), 32'd1);
        check("t4_newadr", Address, 32'h100);
        tick();
        check("t4_cnt", 32'(fifo_count), 32'd1);
        check("t4_pc",  instr_pc, 32'h100);
        check("t4_dat", instr_data, word(32'h100));

        // Redirect coincident with a hit.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        check("t5_cnt0",  32'(fifo_count), 32'd0);
        check("t5_val0",  32'(instr_valid), 32'd0);
        check("t5_prrd0", 32'(PrRd), 32'd0);
        tick();
        check("t5_addr", Address, 32'h40);
        tick();
        check("t5_val", 32'(instr_valid), 32'd1);
        check("t5_pc",  instr_pc, 32'h40);
        check("t5_dat", instr_data, word(32'h40));

        // Asynchronous reset during a miss.
        CPU_stall   = 1'b1;
        instr_ready = 1'b0;
        tick();
        check("t6_wait", Address, 32'h41);
        check("t6_cnt",  32'(fifo_count), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_prrd",  32'(PrRd), 32'd0);
        check("t6_cnt0",  32'(fifo_count), 32'd0);
        check("t6_addr",  Address, 32'd0);
        check("t6_valid", 32'(instr_valid), 32'd0);

        // PC wrap at the top of the address space, then fetch_en drop.
        tick();
        rst_n          = 1'b1;
        CPU_stall      = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("t7_idle", 32'(PrRd), 32'd0);
        tick();
        check("t7_addr_top", Address, 32'hFFFF_FFFF);
        tick();
        check("t7_pc_top", instr_pc, 32'hFFFF_FFFF);
        check("t7_wrap",   Address, 32'd0);
        tick();
        check("t7_pc0",   instr_pc, 32'd0);
        check("t7_dat0",  instr_data, word(32'd0));
        check("t7_addr1", Address, 32'd1);
        fetch_en = 1'b0;
        tick();
        check("t8_pc1",  instr_pc, 32'd1);
        check("t8_stop", 32'(PrRd), 32'd0);
        tick();
        check("t8_cnt0", 32'(fifo_count), 32'd0);
        check("t8_idle", 32'(PrRd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch_unit_i_0
`default_nettype wire
